// File: rtl/rr_grant_arbiter_if.sv
// Requester-side handshake for the round-robin arbiter: request/enable in, registered grant out.
interface rr_grant_arbiter_if #(
   parameter int N   = 8,
   parameter int IDW = 3
);
   logic           en;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic [4:0]     hold_cnt;

   modport master (output en, req, input gnt, gnt_id, gnt_valid, hold_cnt);
   modport slave  (input en, req, output gnt, gnt_id, gnt_valid, hold_cnt);
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with grant hold and programmable forced release; gnt_id drives the
// shared datapath select mux.
module rr_grant_arbiter #(
   parameter int N        = 8,
   parameter int IDW      = 3,
   parameter int MAX_HOLD = 16
) (
   input logic              clk,
   input logic              rst,
   rr_grant_arbiter_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [4:0] HOLD_LAST = (MAX_HOLD == 0) ? 5'd0 : 5'(MAX_HOLD - 1);

   state_t         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] id_q, id_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [4:0]     hold_q, hold_d;

   logic [N-1:0]   cand;
   logic [IDW-1:0] idx;
   logic [IDW-1:0] win;
   logic           found;
   logic           owner_req;
   logic           release_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   // gnt_q is zero in IDLE, so masking with it only excludes the outgoing owner on a release.
   always_comb begin
      cand  = bus.req & ~gnt_q;
      idx   = '0;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = IDW'((int'(ptr_q) + i) % N);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      owner_req = |(bus.req & gnt_q);
      release_c = !bus.en || !owner_req || (MAX_HOLD != 0 && hold_q == HOLD_LAST);
      case (state_q)
         IDLE: begin
            if (bus.en && found) begin
               state_d = BUSY;
               gnt_d   = N'(1) << win;
               id_d    = win;
               hold_d  = '0;
               ptr_d   = IDW'((int'(win) + 1) % N);
            end
         end
         BUSY: begin
            if (!release_c) begin
               if (hold_q != 5'd31) hold_d = hold_q + 5'd1;
            end else if (bus.en && found) begin
               gnt_d  = N'(1) << win;
               id_d   = win;
               hold_d = '0;
               ptr_d  = IDW'((int'(win) + 1) % N);
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               id_d    = '0;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.gnt       = gnt_q;
      bus.gnt_id    = id_q;
      bus.gnt_valid = |gnt_q;
      bus.hold_cnt  = hold_q;
   end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter built with MAX_HOLD = 4 so forced release is reachable.
module tb_rr_grant_arbiter;

   localparam int N   = 8;
   localparam int IDW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   rr_grant_arbiter_if #(.N(N), .IDW(IDW)) bus ();

   rr_grant_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // vld = expected gnt_valid; id is only compared while a grant is expected
   task automatic chk_out(input string tag, input logic vld, input int id, input int hold);
      logic [N-1:0] eg;
      eg = vld ? (N'(1) << id) : '0;
      chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
      chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(vld));
      if (vld) chk({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
      chk({tag, ".hold"}, 32'(bus.hold_cnt), 32'(hold));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int tid[9];
      int thold[9];
      bus.en  = 1'b0;
      bus.req = '0;

      // reset state
      repeat (2) step();
      chk_out("reset", 1'b0, 0, 0);
      chk("reset.id", 32'(bus.gnt_id), 32'd0);
      rst = 1'b0;

      // single request, latency 1, drop one edge after req falls
      bus.en  = 1'b1;
      bus.req = 8'b0000_0100;
      step(); chk_out("single.g", 1'b1, 2, 0);
      step(); chk_out("single.h", 1'b1, 2, 1);
      bus.req = 8'b0000_0000;
      step(); chk_out("single.drop", 1'b0, 0, 0);
      // ptr = 3, so requester 3 beats requester 0
      bus.req = 8'b0000_1001;
      step(); chk_out("ptr3", 1'b1, 3, 0);
      bus.req = '0;
      step(); chk_out("ptr3.drop", 1'b0, 0, 0);

      // fairness: back-to-back 0..7,0
      rst_pulse();
      bus.req = 8'hFF;
      step(); chk_out("rr.first", 1'b1, 0, 0);
      for (int k = 0; k < 8; k++) begin
         step(); chk_out($sformatf("rr.hold%0d", k), 1'b1, k, 1);
         bus.req = 8'hFF & ~(8'(1) << k);
         step(); chk_out($sformatf("rr.next%0d", k), 1'b1, (k + 1) % 8, 0);
         bus.req = 8'hFF;
      end
      bus.req = '0;
      step(); chk_out("rr.drop", 1'b0, 0, 0);

      // timeout with two requesters
      rst_pulse();
      bus.req = 8'b1000_0001;
      tid   = '{0, 0, 0, 0, 7, 7, 7, 7, 0};
      thold = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      for (int i = 0; i < 9; i++) begin
         step(); chk_out($sformatf("tmo%0d", i), 1'b1, tid[i], thold[i]);
      end

      // sole requester timeout: 4 on, 1 off
      rst_pulse();
      bus.req = 8'b0010_0000;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) begin
            step(); chk_out($sformatf("sole%0d.%0d", r, i), 1'b1, 5, i);
         end
         step(); chk_out($sformatf("sole%0d.gap", r), 1'b0, 0, 0);
      end

      // enable drop
      rst_pulse();
      bus.req = 8'b0000_1000;
      step(); chk_out("en.g3", 1'b1, 3, 0);
      step(); chk_out("en.h3", 1'b1, 3, 1);
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk_out($sformatf("en.off%0d", i), 1'b0, 0, 0);
      end
      bus.en  = 1'b1;
      bus.req = 8'b0001_1000;
      step(); chk_out("en.resume", 1'b1, 4, 0);

      // async reset mid-tenure
      bus.req = 8'b0100_0000;
      step(); chk_out("ar.g6", 1'b1, 6, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("ar.async", 1'b0, 0, 0);
      rst = 1'b0;
      bus.req = 8'hC1;
      step(); chk_out("ar.after", 1'b1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
